// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the chunked add scheduler.
package adder_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CHUNK_W = 7;

    // Index width for n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_prefix_add7.sv
// 7-bit Kogge-Stone adder (prefix_add7) assembled from single-gate cells.
// Carry-in is folded in as an extra generate at position 0.
module xor_cell (
    input  logic a,
    input  logic b,
    output logic z
);
    assign z = a ^ b;
endmodule

module and_cell (
    input  logic a,
    input  logic b,
    output logic z
);
    assign z = a & b;
endmodule

module two_combine_g (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    output logic g
);
    assign g = gh | (ph & gl);
endmodule

module prefix_add7 (
    input  logic [6:0] a,
    input  logic [6:0] b,
    input  logic       cin,
    output logic [6:0] z,
    output logic       cout
);
    // Position 0 is cin (generate only); positions 1..7 are bits 0..6.
    logic [7:0] g [0:3];
    logic [7:0] p [0:2];
    logic       unused_p;

    assign g[0][0] = cin;
    assign p[0][0] = 1'b0;

    for (genvar i = 0; i < 7; i++) begin : g_pg
        xor_cell u_p (.a(a[i]), .b(b[i]), .z(p[0][i+1]));
        and_cell u_g (.a(a[i]), .b(b[i]), .z(g[0][i+1]));
    end

    for (genvar l = 0; l < 3; l++) begin : g_lvl
        localparam int D = 1 << l;
        for (genvar i = 0; i < 8; i++) begin : g_bit
            if (i >= D) begin : g_comb
                two_combine_g u_g (.gh(g[l][i]), .ph(p[l][i]), .gl(g[l][i-D]), .g(g[l+1][i]));
                if (l < 2) begin : g_p
                    and_cell u_p (.a(p[l][i]), .b(p[l][i-D]), .z(p[l+1][i]));
                end
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                if (l < 2) begin : g_p
                    assign p[l+1][i] = p[l][i];
                end
            end
        end
    end

    // Low group-propagates of the last level have no consumer.
    assign unused_p = ^p[2][3:0];

    for (genvar i = 0; i < 7; i++) begin : g_sum
        xor_cell u_s (.a(p[0][i+1]), .b(g[3][i]), .z(z[i]));
    end

    assign cout = g[3][7];

endmodule

// File: rtl/adder_seq.sv
// Round-robin add scheduler pushing one 7-bit chunk per cycle through a shared adder.
// Optional ADDER_SEQ_OVF_EN adds rsp_ovf (signed overflow of the W-bit add).
module adder_seq
    import adder_seq_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int CHUNKS = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ*CHUNK_W*CHUNKS-1:0]   req_a,
    input  logic [NREQ*CHUNK_W*CHUNKS-1:0]   req_b,
    input  logic [NREQ-1:0]                  req_cin,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [CHUNK_W*CHUNKS-1:0]        rsp_sum,
    output logic                             rsp_cout,
    output logic [id_width(NREQ)-1:0]        rsp_id,
`ifdef ADDER_SEQ_OVF_EN
    output logic                             rsp_ovf,
`endif
    output logic                             busy
);

    localparam int W   = CHUNK_W * CHUNKS;
    localparam int IDW = id_width(NREQ);
    localparam int IXW = id_width(CHUNKS);

    state_t               state, state_nx;
    logic [IDW-1:0]       ptr, id_q, gnt_id, cand;
    logic                 gnt_any;
    logic [IXW-1:0]       idx;
    logic                 carry;
    logic [W-1:0]         op_a, op_b, sum_q;
    logic                 cout_q;
    logic [CHUNK_W-1:0]   ca, cb, cz;
    logic                 c_out;
    logic                 last;
`ifdef ADDER_SEQ_OVF_EN
    logic                 ovf_q;
`endif

    // First valid requester at or above ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && reset && gnt_any)
            req_ready[gnt_id] = 1'b1;
    end

    assign last = (idx == IXW'(CHUNKS - 1));
    assign ca   = op_a[int'(idx)*CHUNK_W +: CHUNK_W];
    assign cb   = op_b[int'(idx)*CHUNK_W +: CHUNK_W];

    prefix_add7 u_add (
        .a    (ca),
        .b    (cb),
        .cin  (carry),
        .z    (cz),
        .cout (c_out)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (gnt_any)   state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            id_q   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (gnt_any) begin
                    op_a  <= req_a[int'(gnt_id)*W +: W];
                    op_b  <= req_b[int'(gnt_id)*W +: W];
                    carry <= req_cin[gnt_id];
                    idx   <= '0;
                    id_q  <= gnt_id;
                end
                RUN: begin
                    sum_q[int'(idx)*CHUNK_W +: CHUNK_W] <= cz;
                    carry <= c_out;
                    idx   <= idx + IXW'(1);
                    if (last) begin
                        cout_q <= c_out;
`ifdef ADDER_SEQ_OVF_EN
                        // cz[MSB] is sum bit W-1 on the last chunk.
                        ovf_q  <= (op_a[W-1] ~^ op_b[W-1]) & (cz[CHUNK_W-1] ^ op_a[W-1]);
`endif
                    end
                end
                DONE: if (rsp_ready)
                    ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;
`ifdef ADDER_SEQ_OVF_EN
    assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq: arbitration and arithmetic predicted from plain integer math.
module tb_adder_seq;

    localparam int NREQ = 4, CHUNKS = 4, W = 28, IDW = 2;

    logic                 clock = 1'b0, reset = 1'b0;
    logic [NREQ-1:0]      req_valid = '0, req_ready, req_cin = '0;
    logic [NREQ*W-1:0]    req_a = '0, req_b = '0;
    logic                 rsp_valid, rsp_ready = 1'b0, rsp_cout, busy;
    logic [W-1:0]         rsp_sum;
    logic [IDW-1:0]       rsp_id;
`ifdef ADDER_SEQ_OVF_EN
    logic                 rsp_ovf;
`endif

    always #5 clock = ~clock;

    adder_seq #(.NREQ(NREQ), .CHUNKS(CHUNKS)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
`ifdef ADDER_SEQ_OVF_EN
        .rsp_ovf(rsp_ovf),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           id;
        logic         ovf;
    } exp_t;

    exp_t            sb[$];
    int              id_log[$];
    int              checks = 0, errors = 0, cyc = 0, nrsp = 0;
    int              ptr_m = 0, gcyc = 0, mode = 0;
    bit              mbusy = 0, rst_seen = 0;
    logic [NREQ-1:0] granted = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input int id);
        exp_t    r;
        longint  s;
        s      = longint'(a) + longint'(b) + longint'(c);
        r.sum  = s[W-1:0];
        r.cout = s[W];
        r.id   = id;
        r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Monitor / scoreboard
    always @(negedge clock) begin
        int              g;
        logic [NREQ-1:0] exp_rdy;
        cyc++;
        if (!reset) begin
            sb.delete();
            mbusy    = 0;
            ptr_m    = 0;
            granted  = '0;
            rst_seen = 1;
        end else begin
            if (rst_seen) begin
                check("reset_rsp_valid", rsp_valid, 0);
                check("reset_busy", busy, 0);
                check("reset_sum", rsp_sum, 0);
                check("reset_cout", rsp_cout, 0);
                check("reset_id", rsp_id, 0);
                rst_seen = 0;
            end
            g       = pick(req_valid, ptr_m);
            exp_rdy = (!mbusy && g >= 0) ? NREQ'(1 << g) : '0;
            check("req_ready", req_ready, exp_rdy);
            check("busy", busy, mbusy);
            check("rsp_valid", rsp_valid, mbusy && (cyc - gcyc >= CHUNKS + 1));
            granted = exp_rdy;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got response id %0d expected none", rsp_id);
                end else begin
                    check("rsp_sum", rsp_sum, sb[0].sum);
                    check("rsp_cout", rsp_cout, sb[0].cout);
                    check("rsp_id", rsp_id, sb[0].id);
`ifdef ADDER_SEQ_OVF_EN
                    check("rsp_ovf", rsp_ovf, sb[0].ovf);
`endif
                    if (rsp_ready) begin
                        id_log.push_back(sb[0].id);
                        void'(sb.pop_front());
                        nrsp++;
                        mbusy = 0;
                    end
                end
            end
            if (exp_rdy != '0) begin
                sb.push_back(ref_add(req_a[g*W +: W], req_b[g*W +: W], req_cin[g], g));
                ptr_m = (g + 1) % NREQ;
                mbusy = 1;
                gcyc  = cyc;
            end
        end
    end

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic c);
        req_valid[i]     = v;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_cin[i]       = c;
    endtask

    // mode 0: granted requester drops; 1: re-presents new data; 2: random traffic
    task automatic tick();
        @(posedge clock); #1;
        for (int i = 0; i < NREQ; i++) begin
            if (mode == 0 && granted[i])
                req_valid[i] = 1'b0;
            else if (mode == 1 && granted[i])
                set_req(i, 1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
            else if (mode == 2 && (granted[i] || $urandom_range(0, 7) == 0))
                set_req(i, 1'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)));
        end
        if (mode == 2) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
        id_log.delete();
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (nrsp < target && n < budget) begin tick(); n++; end
        if (nrsp < target) begin
            checks++; errors++;
            $display("FAIL wait_rsp: got %0d responses expected %0d", nrsp, target);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (mbusy && n < budget) begin tick(); n++; end
        if (mbusy) begin
            checks++; errors++;
            $display("FAIL drain: got busy after %0d cycles expected idle", budget);
        end
    endtask

    task automatic one_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        set_req(i, 1'b1, a, b, c);
        wait_rsp(nrsp + 1, 30);
        drain(30);
    endtask

    initial begin
        int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
        int n;

        do_reset(3);
        rsp_ready = 1'b1;

        // Carry chaining and full ripple
        one_op(0, 28'h0000001, 28'h0000001, 1'b0);
        one_op(2, 28'hFFFFFFF, 28'h0000000, 1'b1);
        one_op(2, 28'hFFFFFFF, 28'hFFFFFFF, 1'b1);
`ifdef ADDER_SEQ_OVF_EN
        one_op(1, 28'h7FFFFFF, 28'h0000001, 1'b0);
        one_op(3, 28'h8000000, 28'h8000000, 1'b0);
`endif

        // Round-robin with everyone requesting
        do_reset(2);
        mode = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
        wait_rsp(nrsp + 6, 100);
        mode = 0;
        req_valid = '0;
        drain(30);
        for (int k = 0; k < 6; k++)
            check("rr_order", (k < id_log.size()) ? id_log[k] : -1, exp_ids[k]);

        // Backpressure: hold the response for 10 cycles while another request waits
        rsp_ready = 1'b0;
        set_req(3, 1'b1, rnd(), rnd(), 1'b1);
        n = 0;
        while (!rsp_valid && n < 30) begin tick(); n++; end
        check("bp_valid_seen", rsp_valid, 1);
        set_req(1, 1'b1, rnd(), rnd(), 1'b0);
        repeat (10) tick();
        rsp_ready = 1'b1;
        id_log.delete();
        wait_rsp(nrsp + 2, 40);
        drain(30);
        check("bp_first", (id_log.size() > 0) ? id_log[0] : -1, 3);
        check("bp_next", (id_log.size() > 1) ? id_log[1] : -1, 1);

        // Reset in the second RUN cycle
        set_req(1, 1'b1, rnd(), rnd(), 1'b0);
        n = 0;
        while (!mbusy && n < 20) begin tick(); n++; end
        tick();
        reset = 1'b0;
        set_req(3, 1'b1, rnd(), rnd(), 1'b1);
        set_req(0, 1'b1, rnd(), rnd(), 1'b0);
        tick();
        reset = 1'b1;
        id_log.delete();
        wait_rsp(nrsp + 2, 40);
        drain(30);
        check("post_reset_first", (id_log.size() > 0) ? id_log[0] : -1, 0);
        check("post_reset_second", (id_log.size() > 1) ? id_log[1] : -1, 3);

        // Random traffic with random backpressure
        mode = 2;
        repeat (400) tick();
        mode = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        drain(30);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_seq.md
# adder_seq

Multi-cycle, multi-requester add scheduler built around one shared 7-bit parallel-prefix adder. It arbitrates round-robin among NREQ requesters, each presenting a 7·CHUNKS-bit add. It sequences the granted operation through the adder one 7-bit chunk per cycle, chaining the carry in a register. The completed sum, carry-out and requester id are held on a valid/ready response port until the consumer accepts them.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥1)
- CHUNKS, 4, 7-bit chunks per operand (≥1); W = 7·CHUNKS

Ports:
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero
- req_a  in  NREQ·W  packed operand A, requester i at [i·W +: W]
- req_b  in  NREQ·W  packed operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  W  sum
- rsp_cout  out  1  carry out of bit W-1
- rsp_id  out  IDW  granted requester index, IDW = max(1, clog2(NREQ))
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - The grant g is the first i with req_valid[i] = 1, searching upward from ptr with wrap.
  - req_ready[g] = 1 combinationally in the same cycle; all other ready bits = 0.
  - On that edge: capture req_a[g], req_b[g] and req_cin[g] into operand registers; carry ← cin; idx ← 0; id ← g; go to RUN.
  - With no valid request, stay in IDLE.
- RUN:
  - The adder computes op_a[idx], op_b[idx] and carry, where [idx] is the 7-bit chunk idx·7 +: 7.
  - The chunk result is written to sum[idx]; carry ← cout; idx ← idx+1.
  - When idx = CHUNKS-1, the final carry goes to rsp_cout and the FSM goes to DONE.
- DONE:
  - rsp_valid = 1.
  - On rsp_valid & rsp_ready: ptr ← (id+1) mod NREQ; go to IDLE.
- req_ready is 0 in RUN and DONE. Operands are sampled only on the grant edge, so later changes on req_* have no effect.
- A requester may drop req_valid before being granted. No obligation is implied.
- The arithmetic result is exact: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(W+1).
- Reset (reset = 0 at an edge) applies regardless of state:
  - state ← IDLE, ptr ← 0, idx ← 0, carry ← 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, busy = 0, req_ready = 0.
  - An in-flight operation is discarded and no response is produced.

## Timing
- Accept at edge t. RUN occupies cycles t+1 through t+CHUNKS. rsp_valid rises after edge t+CHUNKS, so it is first visible in cycle t+CHUNKS+1.
- The earliest next accept is the cycle after the response handshake. Peak throughput is one operation per CHUNKS+2 cycles.
- rsp_sum, rsp_cout and rsp_id are registered and stable while rsp_valid = 1 and rsp_ready = 0.
- req_ready depends combinationally on req_valid and state. It is never registered.
- The adder path is combinational within one cycle: operand mux, then prefix adder, then sum/carry registers.
- CHUNKS = 1: RUN lasts exactly one cycle.
- NREQ = 1: ptr is constant 0.

## Configuration
- ADDER_SEQ_OVF_EN defined:
  - Adds output rsp_ovf (1 bit), the signed two's-complement overflow of the W-bit add.
  - rsp_ovf = (a[W-1] ~^ b[W-1]) & (sum[W-1] ^ a[W-1]), computed from the captured operands and registered in DONE.
  - Reset value is 0.
- ADDER_SEQ_OVF_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package adder_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - CHUNK_W = 7
  - a function computing IDW from NREQ
- Sub-module prefix_add7: the 7-bit parallel-prefix adder with inputs a[6:0], b[6:0], cin and outputs z[6:0], cout. It is built from the team's Xor/And/TwoCombineG gate cells and instantiated once.
- The arbiter, FSM, chunk mux and result registers live in adder_seq.

## Test plan
NREQ = 4, CHUNKS = 4, W = 28.
- Carry chaining: req0 a=0x0000001, b=0x0000001, cin=0, accepted at edge t → rsp_valid in cycle t+5; sum=0x0000002, cout=0, id=0.
- Full carry ripple: req2 a=0xFFFFFFF, b=0x0000000, cin=1 → sum=0x0000000, cout=1, id=2. Also a=0xFFFFFFF, b=0xFFFFFFF, cin=1 → sum=0xFFFFFFF, cout=1.
- Round-robin fairness: all four req_valid held high, rsp_ready=1 → response ids 0,1,2,3,0,1 in order, with exactly one req_ready pulse per grant.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → sum, cout and id unchanged; req_ready=0 throughout; the handshake then returns the FSM to IDLE and the next grant follows.
- Reset mid-operation: reset=0 in the second RUN cycle → next cycle rsp_valid=0, busy=0; after release, req3 and req0 both valid → req0 granted first (ptr=0).
- With ADDER_SEQ_OVF_EN: a=0x7FFFFFF, b=0x0000001, cin=0 → sum=0x8000000, ovf=1, cout=0; a=0x8000000, b=0x8000000 → sum=0, ovf=1, cout=1.
